ula_multipalavra_seq: RTL

Sequential initiator that drives the combinational ULA_AR to compute N_WORDS·WORD_W-bit add/subtract, one ALU word per clock. Word 0 gets a plain op. Each higher word gets the carry/borrow-chained op (add-with-increment / subtract-with-decrement), selected from the ALU carry flag captured on the previous word. Sits between the control unit and ULA_AR; produces the full-width result and aggregated Z/C/S/O flags.

---
 rtl/ula_multipalavra_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ula_multipalavra_seq.sv
// Word-serial multi-precision add/subtract sequencer driving the combinational ULA_AR.
// One ALU word per clock, carry/borrow chained through the ALU carry flag.
module ula_multipalavra_seq #(
  parameter int         WORD_W    = 3,
  parameter int         N_WORDS   = 2,
  parameter logic [4:0] OP_ADD    = 5'b00000,
  parameter logic [4:0] OP_ADDINC = 5'b00001,
  parameter logic [4:0] OP_SUB    = 5'b00010,
  parameter logic [4:0] OP_SUBDEC = 5'b00100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        op_sub,
  input  logic [WORD_W*N_WORDS-1:0]   opa_in,
  input  logic [WORD_W*N_WORDS-1:0]   opb_in,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_W*N_WORDS-1:0]   result,
  output logic                        carry_out,
  output logic                        overflow,
  output logic                        sign,
  output logic                        zero,
  output logic [WORD_W-1:0]           ula_a,
  output logic [WORD_W-1:0]           ula_b,
  output logic [4:0]                  ula_op,
  input  logic [WORD_W-1:0]           ula_resu,
  input  logic                        ula_c,
  input  logic                        ula_o,
  input  logic                        ula_s,
  input  logic                        ula_z
);

  localparam int TOT_W = WORD_W * N_WORDS;
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TOT_W-1:0]   opa_q;
  logic [TOT_W-1:0]   opb_q;
  logic               sub_q;
  logic               carry_q;
  logic               zacc_q;
  logic [TOT_W-1:0]   result_q;
  logic               carry_out_q;
  logic               overflow_q;
  logic               sign_q;
  logic               zero_q;
  logic               done_q;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign sign      = sign_q;
  assign zero      = zero_q;

  // For subtraction the ALU C flag means "no borrow", so a clear C selects the decrementing op.
  always_comb begin
    ula_a  = '0;
    ula_b  = '0;
    ula_op = OP_ADD;
    if (state_q == RUN) begin
      ula_a = opa_q[idx_q*WORD_W +: WORD_W];
      ula_b = opb_q[idx_q*WORD_W +: WORD_W];
      if (idx_q == '0)
        ula_op = sub_q ? OP_SUB : OP_ADD;
      else if (!sub_q)
        ula_op = carry_q ? OP_ADDINC : OP_ADD;
      else
        ula_op = carry_q ? OP_SUB : OP_SUBDEC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q   <= opa_in;
            opb_q   <= opb_in;
            sub_q   <= op_sub;
            idx_q   <= '0;
            zacc_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q[idx_q*WORD_W +: WORD_W] <= ula_resu;
          carry_q <= ula_c;
          zacc_q  <= zacc_q & ula_z;
          if (idx_q == LAST_IDX) begin
            carry_out_q <= ula_c;
            overflow_q  <= ula_o;
            sign_q      <= ula_s;
            zero_q      <= zacc_q & ula_z;
            done_q      <= 1'b1;
            state_q     <= FIM;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        FIM: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
